// File: rtl/result_deskew_fifo.sv
// rtl/result_deskew_fifo.sv - column deskew and row FIFO for systolic-array south-edge results
//
// Re-aligns skewed columns (column c arrives c cycles after column 0) into
// whole rows, buffers them in a DEPTH-entry FIFO and presents them on a
// ready/valid interface.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset, highest priority
//   flush_i      synchronous clear of deskew valids, FIFO and error flags
//   in_valid_i   column-0 element of a new row is valid this cycle
//   in_data_i    packed south-edge results, column c in slice c
//   stall_o      upstream must not start new rows
//   out_valid_o  FIFO head row valid
//   out_ready_i  host accepts head row
//   out_data_o   FIFO head row, column c in slice c
//   count_o      occupied FIFO entries
//   overflow_o   sticky: an aligned row was dropped on a full FIFO
//   underflow_o  sticky: out_ready_i seen while out_valid_o was low
module result_deskew_fifo #(
   parameter int WIDTH = 8,
   parameter int COL   = 4,
   parameter int DEPTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   input  logic [COL-1:0][WIDTH-1:0]    in_data_i,
   output logic                         stall_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [COL-1:0][WIDTH-1:0]    out_data_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic                         overflow_o,
   output logic                         underflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [CW:0]   STALL_TH = (CW+1)'(DEPTH - 1);

   logic                      clear;
   logic [COL-2:0]            vpipe_q;
   logic                      aligned_valid;
   logic [COL-1:0][WIDTH-1:0] aligned_row;

   logic [COL-1:0][WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]             wptr_q, rptr_q, rptr_nxt;
   logic [CW-1:0]             count_q, count_nxt;
   logic                      valid_q, ovf_q, udf_q, stall_q;
   logic [COL-1:0][WIDTH-1:0] data_q, head_nxt;
   logic                      pop, push, full;
   logic [CW:0]               inflight;

   assign clear = rst_i | flush_i;

   // Row valid travels COL-1 stages so it lines up with the last column.
   always_ff @(posedge clk_i) begin
      if (clear) begin
         vpipe_q <= '0;
      end else begin
         vpipe_q[0] <= in_valid_i;
         for (int i = 1; i < COL - 1; i++) begin
            vpipe_q[i] <= vpipe_q[i-1];
         end
      end
   end

   assign aligned_valid = vpipe_q[COL-2];

   // Column c is delayed COL-1-c cycles; the last column is used directly.
   for (genvar c = 0; c < COL - 1; c++) begin : g_col
      localparam int NS = COL - 1 - c;
      logic [WIDTH-1:0] sr [NS];
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int k = 0; k < NS; k++) begin
               sr[k] <= '0;
            end
         end else begin
            sr[0] <= in_data_i[c];
            for (int k = 1; k < NS; k++) begin
               sr[k] <= sr[k-1];
            end
         end
      end
      assign aligned_row[c] = sr[NS-1];
   end
   assign aligned_row[COL-1] = in_data_i[COL-1];

   assign pop  = valid_q & out_ready_i;
   assign full = (count_q == FULL);
   assign push = aligned_valid & (~full | pop);

   always_comb begin
      rptr_nxt  = pop ? rptr_q + AW'(1) : rptr_q;
      count_nxt = count_q;
      if (push && !pop) begin
         count_nxt = count_q + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count_q - CW'(1);
      end
      // The next head is being written this very cycle only when the FIFO
      // is (or becomes) empty; otherwise it already sits in memory.
      if (push && (wptr_q == rptr_nxt)) begin
         head_nxt = aligned_row;
      end else begin
         head_nxt = mem[rptr_nxt];
      end
      inflight = {{CW{1'b0}}, in_valid_i};
      for (int i = 0; i < COL - 1; i++) begin
         inflight = inflight + {{CW{1'b0}}, vpipe_q[i]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !clear) begin
         mem[wptr_q] <= aligned_row;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         stall_q <= 1'b0;
         data_q  <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         rptr_q  <= rptr_nxt;
         count_q <= count_nxt;
         valid_q <= (count_nxt != '0);
         if (aligned_valid && full && !pop) begin
            ovf_q <= 1'b1;
         end
         if (out_ready_i && !valid_q) begin
            udf_q <= 1'b1;
         end
         // Empty FIFO keeps showing the last head row.
         if (count_nxt != '0) begin
            data_q <= head_nxt;
         end
         stall_q <= (({1'b0, count_q} + inflight) >= STALL_TH);
      end
   end

   assign stall_o     = stall_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = udf_q;

endmodule

// File: tb/tb_result_deskew_fifo.sv
// tb/tb_result_deskew_fifo.sv - scoreboard bench for result_deskew_fifo
module tb_result_deskew_fifo;

   localparam int WIDTH = 8;
   localparam int COL   = 4;
   localparam int DEPTH = 8;

   typedef logic [COL-1:0][WIDTH-1:0] row_t;
   typedef struct {
      int   start;
      row_t row;
   } pend_t;

   logic                  clk = 1'b0;
   logic                  rst_i = 1'b1;
   logic                  flush_i = 1'b0;
   logic                  in_valid_i = 1'b0;
   row_t                  in_data_i = '0;
   logic                  stall_o;
   logic                  out_valid_o;
   logic                  out_ready_i = 1'b0;
   row_t                  out_data_o;
   logic [$clog2(DEPTH):0] count_o;
   logic                  overflow_o;
   logic                  underflow_o;

   result_deskew_fifo #(.WIDTH(WIDTH), .COL(COL), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .stall_o     (stall_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .count_o     (count_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: partial rows being assembled from the bus, the FIFO
   // contents as a queue, and the sticky flags.
   pend_t pend[$];
   row_t  exp_q[$];
   row_t  hold_val = '0;
   bit    e_ovf = 0, e_udf = 0, e_stall = 0, armed = 0;
   int    mcyc = 0;

   always @(posedge clk) begin
      if (rst_i || flush_i) begin
         pend.delete();
         exp_q.delete();
         e_ovf    = 0;
         e_udf    = 0;
         e_stall  = 0;
         hold_val = '0;
         if (rst_i) armed = 1;
      end else begin
         if (in_valid_i) pend.push_back('{start: mcyc, row: '0});
         for (int i = 0; i < pend.size(); i++) begin
            pend_t p;
            int    c;
            p = pend[i];
            c = mcyc - p.start;
            p.row[c] = in_data_i[c];
            pend[i] = p;
         end
         while (pend.size() > 0 && (mcyc - pend[0].start) == COL - 1) begin
            pend_t p;
            p = pend.pop_front();
            if (exp_q.size() < DEPTH) exp_q.push_back(p.row);
            else e_ovf = 1;
         end
      end
      mcyc++;
   end

   // Monitor: compares status every cycle and pops the scoreboard on a
   // handshake.
   always @(negedge clk) begin
      if (armed) begin
         int sz;
         sz = exp_q.size();
         check("out_valid", 64'(out_valid_o), 64'(sz != 0));
         check("count", 64'(count_o), 64'(sz));
         check("overflow", 64'(overflow_o), 64'(e_ovf));
         check("underflow", 64'(underflow_o), 64'(e_udf));
         check("stall", 64'(stall_o), 64'(e_stall));
         if (sz == 0) begin
            check("idle_data", 64'(out_data_o), 64'(hold_val));
            if (out_ready_i) e_udf = 1;
         end else if (out_ready_i) begin
            row_t r;
            r = exp_q.pop_front();
            check("row_data", 64'(out_data_o), 64'(r));
            hold_val = r;
         end
         e_stall = (sz + pend.size() + int'(in_valid_i)) >= DEPTH - 1;
      end
   end

   // Driver: places each column of every issued row on the bus in its slot,
   // random garbage everywhere else.
   pend_t drv[$];
   int    dcyc = 0;

   function automatic row_t rand_row();
      row_t r;
      for (int c = 0; c < COL; c++) r[c] = WIDTH'($urandom);
      return r;
   endfunction

   function automatic row_t seq_row(input int k);
      row_t r;
      for (int c = 0; c < COL; c++) r[c] = WIDTH'(8 * k + c);
      return r;
   endfunction

   task automatic step(input bit v, input row_t r, input bit rdy, input bit fl, input bit rs);
      row_t d;
      d = rand_row();
      in_valid_i  = v;
      out_ready_i = rdy;
      flush_i     = fl;
      rst_i       = rs;
      if (v) drv.push_back('{start: dcyc, row: r});
      for (int i = 0; i < drv.size(); i++) begin
         int c;
         c = dcyc - drv[i].start;
         d[c] = drv[i].row[c];
      end
      while (drv.size() > 0 && (dcyc - drv[0].start) == COL - 1) void'(drv.pop_front());
      if (fl || rs) drv.delete();
      in_data_i = d;
      @(posedge clk);
      #1;
      dcyc++;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, '0, rdy, 0, 0);
   endtask

   initial begin
      bit   stall_seen;
      int   issued;
      row_t one;

      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      check("rst_valid", 64'(out_valid_o), 64'(0));
      check("rst_count", 64'(count_o), 64'(0));
      check("rst_data", 64'(out_data_o), 64'(0));
      idle(3, 0);

      // Single row, latency COL
      one = '0;
      one[0] = 8'h11; one[1] = 8'h22; one[2] = 8'h33; one[3] = 8'h44;
      step(1, one, 0, 0, 0);
      idle(3, 0);
      check("single_valid", 64'(out_valid_o), 64'(1));
      check("single_data", 64'(out_data_o), 64'h44332211);
      check("single_count", 64'(count_o), 64'(1));
      step(0, '0, 1, 0, 0);
      check("single_pop_count", 64'(count_o), 64'(0));
      check("single_pop_valid", 64'(out_valid_o), 64'(0));
      idle(2, 0);

      // Back-to-back fill to full
      stall_seen = 0;
      for (int k = 0; k < 8; k++) begin
         step(1, seq_row(k), 0, 0, 0);
         if (stall_o) stall_seen = 1;
      end
      for (int i = 0; i < 3; i++) begin
         step(0, '0, 0, 0, 0);
         if (i < 2 && stall_o) stall_seen = 1;
      end
      check("b2b_stall_seen", 64'(stall_seen), 64'(1));
      idle(2, 0);
      check("b2b_count", 64'(count_o), 64'(8));
      check("b2b_ovf", 64'(overflow_o), 64'(0));

      // Full with a same-cycle pop on the write cycle
      step(1, seq_row(8), 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      idle(2, 0);
      check("simul_count", 64'(count_o), 64'(8));
      check("simul_ovf", 64'(overflow_o), 64'(0));

      // Overflow ignoring stall
      step(1, seq_row(9), 0, 0, 0);
      idle(5, 0);
      check("ovf_flag", 64'(overflow_o), 64'(1));
      check("ovf_count", 64'(count_o), 64'(8));
      idle(8, 1);
      check("drain_count", 64'(count_o), 64'(0));
      idle(2, 0);
      step(0, '0, 0, 1, 0);
      check("flush_clears_ovf", 64'(overflow_o), 64'(0));
      check("flush_clears_udf", 64'(underflow_o), 64'(0));

      // Wrap-around with toggling ready, honouring stall
      issued = 0;
      for (int i = 0; i < 200 && issued < 20; i++) begin
         bit v;
         v = !stall_o;
         step(v, rand_row(), i[0], 0, 0);
         if (v) issued++;
      end
      check("wrap_issued", 64'(issued), 64'(20));
      idle(DEPTH * 2 + COL, 1);
      check("wrap_drained", 64'(count_o), 64'(0));

      // Random traffic with occasional stall violation and flush
      for (int i = 0; i < 600; i++) begin
         bit v, rdy, fl;
         v   = ($urandom_range(0, 1) == 1) && (!stall_o || $urandom_range(0, 15) == 0);
         rdy = $urandom_range(0, 2) != 0;
         fl  = $urandom_range(0, 63) == 0;
         step(v, rand_row(), rdy, fl, 0);
      end
      idle(DEPTH * 2, 1);
      step(0, '0, 0, 1, 0);

      // Flush mid-row with 3 rows stored
      for (int k = 0; k < 3; k++) step(1, rand_row(), 0, 0, 0);
      idle(4, 0);
      check("pre_flush_count", 64'(count_o), 64'(3));
      step(1, rand_row(), 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 1, 0);
      check("midflush_count", 64'(count_o), 64'(0));
      check("midflush_valid", 64'(out_valid_o), 64'(0));
      check("midflush_ovf", 64'(overflow_o), 64'(0));
      check("midflush_data", 64'(out_data_o), 64'(0));
      idle(6, 0);

      // Same sequence with reset
      for (int k = 0; k < 3; k++) step(1, rand_row(), 0, 0, 0);
      idle(4, 0);
      check("pre_rst_count", 64'(count_o), 64'(3));
      step(1, rand_row(), 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 1);
      check("midrst_count", 64'(count_o), 64'(0));
      check("midrst_valid", 64'(out_valid_o), 64'(0));
      check("midrst_ovf", 64'(overflow_o), 64'(0));
      check("midrst_stall", 64'(stall_o), 64'(0));
      idle(6, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_deskew_fifo.md
Name: result_deskew_fifo

Overview:
- Sits directly downstream of the systolic-array matrix multiplier in external mode. Consumes the per-column skewed south-edge results (ext_result_o / ext_valid_o).
- Column c of a result row arrives c cycles after column 0. This block re-aligns the columns into complete rows.
- Aligned rows are buffered in a DEPTH-entry FIFO and presented to the host on a ready/valid interface.
- Provides early backpressure and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, bits per result element.
- COL, 4, number of array columns (elements per row); must be >= 2.
- DEPTH, 8, FIFO entries; power of two, >= 2*COL.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous clear of deskew pipeline and FIFO.
- in_valid_i  in  1  column-0 element of a new row is valid this cycle.
- in_data_i  in  COL*WIDTH  packed [COL-1:0][WIDTH-1:0] south-edge results.
- stall_o  out  1  upstream must not start new rows.
- out_valid_o  out  1  FIFO head row valid.
- out_ready_i  in  1  host accepts head row.
- out_data_o  out  COL*WIDTH  FIFO head row, column c in slice c.
- count_o  out  $clog2(DEPTH)+1  occupied FIFO entries.
- overflow_o  out  1  sticky: an aligned row was dropped because the FIFO was full.
- underflow_o  out  1  sticky: out_ready_i was high while out_valid_o was low.

Behaviour:
- Reset (rst_i=1 at an edge): deskew registers, valid pipeline, FIFO pointers and count are cleared. Outputs: out_valid_o=0, count_o=0, stall_o=0, overflow_o=0, underflow_o=0, out_data_o=0. Reset has priority over flush_i and all other inputs. Reset mid-row discards partial rows.
- Input timing: for a row with in_valid_i high in cycle t, column c data is sampled from in_data_i[c] in cycle t+c. in_data_i[c] is ignored in all other cycles.
- Deskew:
  - Column c passes through COL-1-c register stages; column COL-1 is unregistered.
  - in_valid_i passes through a COL-1 stage shift register, so aligned_valid is asserted in cycle t+COL-1.
  - Back-to-back rows (in_valid_i high on consecutive cycles) are supported at one row per cycle.
- FIFO write:
  - When aligned_valid=1 and (count<DEPTH or pop in the same cycle), the aligned row is written at the edge ending cycle t+COL-1.
  - Earliest out_valid_o is cycle t+COL, so latency is COL cycles into an empty FIFO. There is no combinational bypass.
- Full FIFO: if aligned_valid=1, count=DEPTH and there is no pop, the row is dropped, overflow_o is set, and count and data are unchanged.
- Pop: occurs when out_valid_o && out_ready_i. The read pointer advances and out_data_o shows the next entry in the following cycle.
- Simultaneous push and pop: count is unchanged. This holds at both full and empty boundaries. At empty, a same-cycle write is not poppable until the next cycle.
- Pointers: $clog2(DEPTH)-bit, wrap modulo DEPTH. count_o is kept as an explicit register.
- out_valid_o = (count_o != 0), registered.
- out_data_o: reflects the head entry when valid. It holds the last value when empty (0 after reset/flush).
- stall_o is asserted registered when count_o + rows_in_flight >= DEPTH-1.
  - rows_in_flight = number of set bits in the valid pipeline plus the incoming in_valid_i.
  - This guarantees no overflow when upstream honours stall_o within one cycle.
- underflow_o: set when out_ready_i=1 && out_valid_o=0 for a cycle.
  - out_ready_i is expected to be gated by out_valid_o; a high out_ready_i on an empty FIFO is logged as underflow_o.
  - Pointers and count do not change.
- flush_i=1 at an edge:
  - Clears the valid pipeline, pointers, count, overflow_o and underflow_o.
  - Rows currently mid-deskew are discarded.
  - Any in_valid_i in the flush cycle is ignored.
  - Data registers need not be cleared, except that out_data_o reads 0.
- Arithmetic: data is passed through unmodified; no sign or width conversion.

Test Plan:
- Single row (COL=4, WIDTH=8, DEPTH=8): in_valid_i at cycle 0, then in_data_i[0]=0x11@0, [1]=0x22@1, [2]=0x33@2, [3]=0x44@3. Expect out_valid_o=1 at cycle 4 with out_data_o={0x44,0x33,0x22,0x11} and count_o=1. Pop at cycle 4; expect count_o=0 and out_valid_o=0 at cycle 5.
- Back-to-back: 8 consecutive rows, row k carrying element value 8k+c, with out_ready_i=0. Expect count_o=8, overflow_o=0, and stall_o asserted before the 8th row completes. Then drain with out_ready_i=1; expect rows 0..7 in order, one per cycle.
- Overflow: ignore stall_o and push a 9th row with out_ready_i=0. Expect overflow_o=1, count_o stays 8, and the 8 stored rows are unchanged on drain.
- Full plus simultaneous: with count_o=8, push a row while out_ready_i=1 in its write cycle. Expect count_o stays 8, no overflow_o, and the new row is emitted last.
- Wrap-around: 20 rows with out_ready_i toggling 1/0 each cycle. Expect every row delivered intact and in order, and count_o never exceeds 8.
- Flush/reset mid-row:
  - Assert flush_i at cycle 2 of a row with 3 rows already stored. Expect count_o=0, out_valid_o=0 and overflow_o=0 next cycle, and no partial row ever emitted.
  - Repeat the same sequence with rst_i; expect the same result.
